// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - circular-queue controller for an external dual-address RAM
module ram_fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [3:0]        state,
  output logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_wa,
  output logic [ADDR_W-1:0] addr_ra,
  output logic              we_a,
  output logic              re_a,
  input  logic [DATA_W-1:0] q_a
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000,
    ST_ERROR  = 4'b0000
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [ADDR_W:0]   count, count_d;
  logic [ADDR_W:0]   thr_alto, thr_bajo, thr_alto_d, thr_bajo_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              error_q, valid_q;
  logic              accepting, flags_upd;
  logic              push_ok, pop_ok, overflow, underflow;

  always_comb begin
    accepting = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    push_ok   = accepting & push & ~full_q;
    pop_ok    = accepting & pop & ~empty_q;
    overflow  = accepting & push & full_q;
    underflow = accepting & pop & empty_q;
    // Flags only track the count once thresholds are meaningful; frozen in ERROR.
    flags_upd = accepting || (state_q == ST_INIT);
  end

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (push_ok) wr_ptr_d = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    if (push_ok && !pop_ok)      count_d = count + 1'b1;
    else if (pop_ok && !push_ok) count_d = count - 1'b1;
  end

  always_comb begin
    thr_alto_d = thr_alto;
    thr_bajo_d = thr_bajo;
    if (state_q == ST_INIT) begin
      thr_alto_d = umbral_alto;
      thr_bajo_d = umbral_bajo;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE,
      ST_ACTIVE: begin
        if (overflow || underflow) state_d = ST_ERROR;
        else if (count_d == '0)    state_d = ST_IDLE;
        else                       state_d = ST_ACTIVE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      thr_alto <= '0;
      thr_bajo <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      count    <= count_d;
      thr_alto <= thr_alto_d;
      thr_bajo <= thr_bajo_d;
      if (flags_upd) begin
        full_q   <= (count_d == DEPTH_C);
        empty_q  <= (count_d == '0);
        afull_q  <= (count_d >= thr_alto_d);
        aempty_q <= (count_d <= thr_bajo_d);
      end
      error_q  <= error_q | overflow | underflow;
      valid_q  <= pop_ok;
    end
  end

  assign we_a           = push_ok;
  assign addr_wa        = wr_ptr;
  assign data_a         = data_in;
  assign re_a           = pop_ok;
  assign addr_ra        = rd_ptr;
  assign data_out       = q_a;
  assign data_out_valid = valid_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign almost_full    = afull_q;
  assign almost_empty   = aempty_q;
  assign fifo_error     = error_q;
  assign state          = state_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [9:0] data_out;
  logic       data_out_valid;
  logic       full, empty, almost_full, almost_empty, fifo_error;
  logic [3:0] state;
  logic [9:0] data_a;
  logic [2:0] addr_wa, addr_ra;
  logic       we_a, re_a;
  logic [9:0] q_a;

  int checks;
  int failures;

  logic [9:0] mem [8];
  logic [9:0] model [$];

  ram_fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .state(state),
    .data_a(data_a), .addr_wa(addr_wa), .addr_ra(addr_ra), .we_a(we_a), .re_a(re_a),
    .q_a(q_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: registered read, valid the cycle after re_a.
  always @(posedge clk) begin
    if (we_a) mem[addr_wa] <= data_a;
    if (re_a) q_a <= mem[addr_ra];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_L = 1'b0; push = 1'b0; pop = 1'b0;
    tick; tick;
    reset_L = 1'b1;
    tick; tick;
  endtask

  task automatic test_reset;
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    tick; tick;
    checks++; if (state !== 4'b0001) begin failures++; $display("FAIL reset_state got=%b exp=0001", state); end
    checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      failures++; $display("FAIL reset_flags got=%b exp=0101", {full, empty, almost_full, almost_empty}); end
    checks++; if ({fifo_error, data_out_valid, we_a, re_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {fifo_error, data_out_valid, we_a, re_a}); end
    checks++; if ({addr_wa, addr_ra} !== 6'd0) begin failures++; $display("FAIL reset_ptrs got=%h exp=0", {addr_wa, addr_ra}); end
    reset_L = 1'b1;
    tick;
    checks++; if (state !== 4'b0010) begin failures++; $display("FAIL init_state got=%b exp=0010", state); end
    tick;
    checks++; if (state !== 4'b0100) begin failures++; $display("FAIL idle_state got=%b exp=0100", state); end
    checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      failures++; $display("FAIL idle_flags got=%b exp=0101", {full, empty, almost_full, almost_empty}); end
  endtask

  task automatic test_push_pop;
    logic [9:0] words [4];
    words[0] = 10'h3FF; words[1] = 10'h2AA; words[2] = 10'h155; words[3] = 10'h3E0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_in = words[i];
      #1;
      checks++; if ({we_a, addr_wa, data_a} !== {1'b1, 3'(i), words[i]}) begin
        failures++; $display("FAIL push_drive%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, we_a, addr_wa, data_a, i, words[i]); end
      tick;
    end
    push = 1'b0;
    checks++; if (state !== 4'b1000) begin failures++; $display("FAIL active_state got=%b exp=1000", state); end
    checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0000) begin
      failures++; $display("FAIL count4_flags got=%b exp=0000", {full, empty, almost_full, almost_empty}); end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      #1;
      checks++; if ({re_a, addr_ra} !== {1'b1, 3'(i)}) begin
        failures++; $display("FAIL pop_drive%0d got re=%b a=%0d exp re=1 a=%0d", i, re_a, addr_ra, i); end
      tick;
      checks++; if ({data_out_valid, data_out} !== {1'b1, words[i]}) begin
        failures++; $display("FAIL pop_data%0d got v=%b d=%h exp v=1 d=%h", i, data_out_valid, data_out, words[i]); end
    end
    pop = 1'b0;
    checks++; if ({state, empty, almost_empty} !== {4'b0100, 2'b11}) begin
      failures++; $display("FAIL drained got st=%b e=%b ae=%b exp st=0100 e=1 ae=1", state, empty, almost_empty); end
    tick;
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL valid_drop got=%b exp=0", data_out_valid); end
  endtask

  task automatic test_full_overflow;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 10'(10'h100 + i);
      #1;
      checks++; if ({we_a, addr_wa} !== {1'b1, 3'((4 + i) % 8)}) begin
        failures++; $display("FAIL fill_drive%0d got we=%b a=%0d exp we=1 a=%0d", i, we_a, addr_wa, (4 + i) % 8); end
      tick;
      checks++; if ({full, almost_full} !== {(i == 7), (i >= 5)}) begin
        failures++; $display("FAIL fill_flags%0d got full=%b af=%b exp full=%b af=%b", i, full, almost_full, (i == 7), (i >= 5)); end
    end
    data_in = 10'h0AB;
    #1;
    checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL ovf_we got=%b exp=0", we_a); end
    tick;
    checks++; if ({fifo_error, state, full} !== {1'b1, 4'b0000, 1'b1}) begin
      failures++; $display("FAIL ovf_err got err=%b st=%b full=%b exp err=1 st=0000 full=1", fifo_error, state, full); end
    pop = 1'b1;
    #1;
    checks++; if ({we_a, re_a} !== 2'b00) begin failures++; $display("FAIL err_ignore got we=%b re=%b exp 00", we_a, re_a); end
    tick;
    checks++; if ({state, data_out_valid, full, fifo_error} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL err_sticky got st=%b v=%b full=%b err=%b exp 0000 0 1 1", state, data_out_valid, full, fifo_error); end
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_underflow;
    do_reset;
    pop = 1'b1;
    #1;
    checks++; if (re_a !== 1'b0) begin failures++; $display("FAIL udf_re got=%b exp=0", re_a); end
    tick;
    pop = 1'b0;
    checks++; if ({state, fifo_error, empty} !== {4'b0000, 1'b1, 1'b1}) begin
      failures++; $display("FAIL udf_err got st=%b err=%b e=%b exp 0000 1 1", state, fifo_error, empty); end
    reset_L = 1'b0;
    tick;
    checks++; if ({state, fifo_error} !== {4'b0001, 1'b0}) begin
      failures++; $display("FAIL udf_reset got st=%b err=%b exp 0001 0", state, fifo_error); end
    reset_L = 1'b1;
  endtask

  task automatic test_back_to_back;
    int wp, rp;
    logic [9:0] w, exp_d;
    do_reset;
    model.delete();
    wp = 0; rp = 0;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; data_in = 10'(10'h050 + i);
      model.push_back(data_in);
      tick;
      wp++;
    end
    for (int i = 0; i < 17; i++) begin
      w = 10'(i * 37 + 5);
      push = 1'b1; pop = 1'b1; data_in = w;
      #1;
      checks++; if ({we_a, re_a, addr_wa, addr_ra} !== {2'b11, 3'(wp), 3'(rp)}) begin
        failures++; $display("FAIL pair_drive%0d got we=%b re=%b wa=%0d ra=%0d exp 1 1 %0d %0d", i, we_a, re_a, addr_wa, addr_ra, wp, rp); end
      exp_d = model.pop_front();
      model.push_back(w);
      tick;
      wp = (wp + 1) % 8; rp = (rp + 1) % 8;
      checks++; if ({data_out_valid, data_out} !== {1'b1, exp_d}) begin
        failures++; $display("FAIL pair_data%0d got v=%b d=%h exp v=1 d=%h", i, data_out_valid, data_out, exp_d); end
      checks++; if ({state, full, empty, almost_full, almost_empty} !== {4'b1000, 4'b0000}) begin
        failures++; $display("FAIL pair_flags%0d got st=%b f=%b%b%b%b exp 1000 0000", i, state, full, empty, almost_full, almost_empty); end
    end
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      exp_d = model.pop_front();
      tick;
      checks++; if ({data_out_valid, data_out} !== {1'b1, exp_d}) begin
        failures++; $display("FAIL drain_data%0d got v=%b d=%h exp v=1 d=%h", i, data_out_valid, data_out, exp_d); end
    end
    pop = 1'b0;
    checks++; if ({state, empty, addr_wa, addr_ra} !== {4'b0100, 1'b1, 3'd4, 3'd4}) begin
      failures++; $display("FAIL wrap_end got st=%b e=%b wa=%0d ra=%0d exp 0100 1 4 4", state, empty, addr_wa, addr_ra); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; data_in = 10'(10'h200 + i);
      tick;
    end
    push = 1'b0;
    pop = 1'b1;
    tick;
    reset_L = 1'b0;
    tick;
    pop = 1'b0;
    checks++; if ({data_out_valid, empty, full, state} !== {1'b0, 1'b1, 1'b0, 4'b0001}) begin
      failures++; $display("FAIL midrst got v=%b e=%b f=%b st=%b exp 0 1 0 0001", data_out_valid, empty, full, state); end
    checks++; if ({addr_wa, addr_ra} !== 6'd0) begin
      failures++; $display("FAIL midrst_ptrs got wa=%0d ra=%0d exp 0 0", addr_wa, addr_ra); end
    reset_L = 1'b1;
    tick; tick;
    checks++; if ({state, empty, almost_empty} !== {4'b0100, 2'b11}) begin
      failures++; $display("FAIL midrst_idle got st=%b e=%b ae=%b exp 0100 1 1", state, empty, almost_empty); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset;
    test_push_pop;
    test_full_overflow;
    test_underflow;
    test_back_to_back;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that sequences the 8x10 dual-address RAM (data_a, addr_wa, addr_ra, we_a, re_a, q_a) as a circular queue. It accepts push/pop requests from one producer and one consumer, owns the write and read pointers and the occupancy count, and drives the RAM control inputs. It reports full/empty and programmable almost-full/almost-empty flags, flags overflow/underflow, and exposes a 4-bit state code.

Parameters:
DATA_W, 10, RAM word width
ADDR_W, 3, RAM address width
DEPTH, 8, number of entries (2**ADDR_W)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_L  input  1  synchronous, active-low reset
push  input  1  write request; data_in is stored when accepted
data_in  input  DATA_W  word to enqueue
pop  input  1  read request
umbral_alto  input  ADDR_W+1  almost-full threshold, sampled only in INIT
umbral_bajo  input  ADDR_W+1  almost-empty threshold, sampled only in INIT
data_out  output  DATA_W  dequeued word (= q_a)
data_out_valid  output  1  data_out valid this cycle
full, empty  output  1 each  occupancy flags
almost_full, almost_empty  output  1 each  threshold flags
fifo_error  output  1  sticky overflow/underflow
state  output  4  RESET=4'b0001, INIT=4'b0010, IDLE=4'b0100, ACTIVE=4'b1000, ERROR=4'b0000
data_a  output  DATA_W  RAM write data
addr_wa, addr_ra  output  ADDR_W each  RAM write/read addresses
we_a, re_a  output  1 each  RAM write/read enables
q_a  input  DATA_W  RAM read data, registered (valid cycle after re_a)

Behaviour:
- Reset: reset_L==0 at a clk edge forces state=RESET, wr_ptr=rd_ptr=0, count=0, data_out_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, fifo_error=0, threshold registers=0. Reset has priority over everything, including mid-operation; in-flight reads are discarded (data_out_valid=0 next cycle).
- FSM: RESET -> INIT on first edge with reset_L=1. INIT, one cycle: latch umbral_alto/umbral_bajo; -> IDLE. IDLE (count==0) <-> ACTIVE (count>0), following the count after the current edge. Any overflow or underflow -> ERROR. ERROR is sticky until reset.
- Acceptance, only in IDLE/ACTIVE: push_ok = push & ~full. pop_ok = pop & ~empty. Flags are the registered values.
- Push while full (with or without pop): overflow. Pop while empty (with or without push): underflow. The violating request is rejected; the other request is still honoured in that cycle; next state = ERROR, fifo_error=1.
- In RESET/INIT, push/pop are ignored and do not set an error. In ERROR, push/pop are ignored, we_a=re_a=0, and the pointers and count are frozen.
- RAM drive (combinational): we_a=push_ok, addr_wa=wr_ptr, data_a=data_in; re_a=pop_ok, addr_ra=rd_ptr. In all other cases we_a=re_a=0.
- Pointers: on push_ok, wr_ptr increments; on pop_ok, rd_ptr increments; both wrap DEPTH-1 -> 0. Count (ADDR_W+1 bits) is +1 for push only, -1 for pop only, and unchanged for both.
- Read latency: data_out_valid is pop_ok registered by one cycle; data_out = q_a. Latency is 1 cycle from the accepted pop edge.
- Simultaneous push and pop on the same address cannot occur. This case requires full or empty, and either condition rejects one request.
- Flags are registered from the next count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=umbral_alto), almost_empty=(count<=umbral_bajo).

Test Plan:
1. Hold reset_L=0 for 2 cycles, then release -> all outputs at reset values; state goes 0001, then 0010, then 0100. Thresholds are latched as 6 (alto) and 2 (bajo).
2. Push 10'h3FF, 10'h2AA, 10'h155, 10'h3E0 -> we_a=1 with addr_wa=0..3; count=4, state=ACTIVE. Pop 4 times -> data_out in the same order, 1 cycle after each re_a; empty=1, state=IDLE.
3. Push 8 words -> full=1 after the 8th push and almost_full=1 from the 6th. A 9th push -> we_a=0, fifo_error=1, state=0000, and later push/pop are ignored until reset.
4. Pop when empty right after INIT -> re_a=0, underflow, ERROR. Apply reset -> state returns to RESET and fifo_error=0.
5. With count=3, hold push and pop together for 5 cycles -> count stays 3, flags are stable, and data stays in order. Run 12 push/pop pairs -> both pointers wrap 7 -> 0 and data is preserved.
6. Apply reset mid-stream with count=5 and a pop in flight -> data_out_valid=0 the next cycle; empty=1, and pointers and count are 0.
